// File: rtl/mem_pkg.sv
// Packet-buffer sram geometry and the shared arbiter state type.
package mem_pkg;
  localparam int ADDR_W        = 6;
  localparam int BLOCK_BITS    = 32;
  localparam int NUM_BLOCKS    = 1 << ADDR_W;
  localparam int NUM_MEM_PORTS = 4;

  typedef enum logic [0:0] {
    ARB_IDLE   = 1'b0,
    ARB_LOCKED = 1'b1
  } arb_state_t;
endpackage

// File: rtl/sram_port_arbiter_if.sv
// Requester-side bundle: per-port write/read requests, grants and broadcast read data.
interface sram_port_arbiter_if #(
  parameter int NUM_PORTS = mem_pkg::NUM_MEM_PORTS
);
  import mem_pkg::*;

  logic [NUM_PORTS-1:0]                 wr_req;
  logic [NUM_PORTS-1:0]                 wr_lock;
  logic [NUM_PORTS-1:0][ADDR_W-1:0]     wr_addr;
  logic [NUM_PORTS-1:0][BLOCK_BITS-1:0] wr_data;
  logic [NUM_PORTS-1:0]                 wr_gnt;
  logic [NUM_PORTS-1:0]                 rd_req;
  logic [NUM_PORTS-1:0]                 rd_lock;
  logic [NUM_PORTS-1:0][ADDR_W-1:0]     rd_addr;
  logic [NUM_PORTS-1:0]                 rd_gnt;
  logic [NUM_PORTS-1:0]                 rd_valid;
  logic [BLOCK_BITS-1:0]                rd_data;

  modport master (
    output wr_req, wr_lock, wr_addr, wr_data, rd_req, rd_lock, rd_addr,
    input  wr_gnt, rd_gnt, rd_valid, rd_data
  );

  modport slave (
    input  wr_req, wr_lock, wr_addr, wr_data, rd_req, rd_lock, rd_addr,
    output wr_gnt, rd_gnt, rd_valid, rd_data
  );
endinterface

// File: rtl/sram_port_arbiter_arb.sv
// Round-robin arbiter with a per-port burst lock; grant is combinational,
// pointer and lock owner are registered.
module rr_lock_arbiter
  import mem_pkg::*;
#(
  parameter  int NUM_PORTS = NUM_MEM_PORTS,
  localparam int PORT_W    = $clog2(NUM_PORTS)
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [NUM_PORTS-1:0] req_i,
  input  logic [NUM_PORTS-1:0] lock_i,
  output logic [NUM_PORTS-1:0] gnt_o,
  output logic                 gnt_vld_o,
  output logic [PORT_W-1:0]    owner_o
);
  arb_state_t        state_q, state_d;
  logic [PORT_W-1:0] ptr_q, ptr_d, own_q, own_d;
  logic              hit;
  logic [PORT_W-1:0] win;

  always_comb begin
    int unsigned       idx;
    logic [PORT_W-1:0] cand;
    idx  = 0;
    cand = '0;
    hit  = 1'b0;
    win  = '0;
    if (state_q == ARB_LOCKED) begin
      hit = req_i[own_q];
      win = own_q;
    end else begin
      for (int i = 0; i < NUM_PORTS; i++) begin
        idx  = (int'(ptr_q) + i) % NUM_PORTS;
        cand = PORT_W'(idx);
        if (!hit && req_i[cand]) begin
          hit = 1'b1;
          win = cand;
        end
      end
    end
    if (!rst_n) hit = 1'b0;
    gnt_o     = hit ? (NUM_PORTS'(1) << win) : '0;
    gnt_vld_o = hit;
    owner_o   = win;
  end

  // A locked owner that stops requesting forfeits the lock; ptr stays put while locked.
  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    own_d   = own_q;
    if (state_q == ARB_LOCKED) begin
      if (!(hit && lock_i[own_q])) state_d = ARB_IDLE;
    end else if (hit) begin
      ptr_d = (win == PORT_W'(NUM_PORTS-1)) ? '0 : win + 1'b1;
      own_d = win;
      if (lock_i[win]) state_d = ARB_LOCKED;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= ARB_IDLE;
      ptr_q   <= '0;
      own_q   <= '0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      own_q   <= own_d;
    end
  end
endmodule

// File: rtl/sram_port_arbiter.sv
// Shares the 1W/1R packet-buffer sram between NUM_PORTS writers and readers,
// with independent write and read arbitration.
module sram_port_arbiter
  import mem_pkg::*;
#(
  parameter  int NUM_PORTS = NUM_MEM_PORTS,
  localparam int PORT_W    = $clog2(NUM_PORTS)
) (
  input  logic                  clk,
  input  logic                  rst_n,
  sram_port_arbiter_if.slave    bus,
  output logic                  sram_we_o,
  output logic [ADDR_W-1:0]     sram_w_addr_o,
  output logic [BLOCK_BITS-1:0] sram_w_data_o,
  output logic [ADDR_W-1:0]     sram_r_addr_o,
  input  logic [BLOCK_BITS-1:0] sram_r_data_i
);
  logic                 wr_hit, rd_hit;
  logic [PORT_W-1:0]    wr_own, rd_own;
  logic [NUM_PORTS-1:0] rd_valid_q, rd_valid_d;

  rr_lock_arbiter #(.NUM_PORTS(NUM_PORTS)) u_wr_arb (
    .clk      (clk),
    .rst_n    (rst_n),
    .req_i    (bus.wr_req),
    .lock_i   (bus.wr_lock),
    .gnt_o    (bus.wr_gnt),
    .gnt_vld_o(wr_hit),
    .owner_o  (wr_own)
  );

  rr_lock_arbiter #(.NUM_PORTS(NUM_PORTS)) u_rd_arb (
    .clk      (clk),
    .rst_n    (rst_n),
    .req_i    (bus.rd_req),
    .lock_i   (bus.rd_lock),
    .gnt_o    (bus.rd_gnt),
    .gnt_vld_o(rd_hit),
    .owner_o  (rd_own)
  );

  always_comb begin
    sram_we_o     = wr_hit;
    sram_w_addr_o = wr_hit ? bus.wr_addr[wr_own] : '0;
    sram_w_data_o = wr_hit ? bus.wr_data[wr_own] : '0;
    sram_r_addr_o = rd_hit ? bus.rd_addr[rd_own] : '0;
    rd_valid_d    = rd_hit ? (NUM_PORTS'(1) << rd_own) : '0;
  end

  // rd_valid tracks the sram's one-cycle read latency.
  always_ff @(posedge clk) begin
    if (!rst_n) rd_valid_q <= '0;
    else        rd_valid_q <= rd_valid_d;
  end

  assign bus.rd_valid = rd_valid_q;
  assign bus.rd_data  = sram_r_data_i;
endmodule
